// File: rtl/eb_arb_pkg.sv
// Shared definitions for the elastic-buffer round-robin arbiter family.
//   arb_state_e : lock-state encoding (ARB_IDLE = free scan, ARB_LOCKED = packet in flight)
//   sel_width() : source-index width for a given requester count
package eb_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode.
// Scans req starting at ptr, wrapping modulo N, and reports the first set bit.
//   req     : request vector
//   ptr     : scan start index (must be < N)
//   gnt_idx : index of the first requester found (0 when none)
//   gnt_any : high when any requester was found
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise a path that skips it would infer a latch.
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = SEL_W'((int'(ptr) + off) % N);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/eb_rr_arb.sv
// Round-robin arbiter feeding a single full-throughput output register.
// One requester wins per cycle; a packet (beats until last=1) keeps the grant.
//   clk, reset_n : clock and synchronous active-low reset
//   t_data/t_last/t_valid/t_ready : N requester streams (data k at [k*T_WIDTH +: T_WIDTH])
//   i_0_data/i_0_sel/i_0_last/i_0_valid/i_0_ready : registered output stream
module eb_rr_arb
  import eb_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int T_WIDTH = 8,
  parameter int SEL_W   = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N*T_WIDTH-1:0] t_data,
  input  logic [N-1:0]         t_last,
  input  logic [N-1:0]         t_valid,
  output logic [N-1:0]         t_ready,
  output logic [T_WIDTH-1:0]   i_0_data,
  output logic [SEL_W-1:0]     i_0_sel,
  output logic                 i_0_last,
  output logic                 i_0_valid,
  input  logic                 i_0_ready
);

  arb_state_e         lock, lock_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [SEL_W-1:0]   lsrc, lsrc_nxt;
  logic [SEL_W-1:0]   pick_idx, winner;
  logic               pick_any, has_winner;
  logic               en, xfer, win_last;
  logic [T_WIDTH-1:0] win_data;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (t_valid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Winner selection, handshake and next lock/pointer state.
  always_comb begin
    en         = ~i_0_valid | i_0_ready;
    winner     = pick_idx;
    has_winner = pick_any;
    // A locked packet owns the output; everyone else stalls even if it idles.
    if (lock == ARB_LOCKED) begin
      winner     = lsrc;
      has_winner = t_valid[lsrc];
    end
    xfer     = en & has_winner;
    win_data = t_data[int'(winner)*T_WIDTH +: T_WIDTH];
    win_last = t_last[winner];

    // Held low during reset so no requester believes a beat was taken.
    t_ready = '0;
    if (xfer && reset_n) t_ready[winner] = 1'b1;

    lock_nxt = lock;
    ptr_nxt  = ptr;
    lsrc_nxt = lsrc;
    if (xfer) begin
      if (win_last) begin
        // Pointer only moves on packet completion.
        lock_nxt = ARB_IDLE;
        ptr_nxt  = (winner == SEL_W'(N - 1)) ? '0 : winner + 1'b1;
      end else begin
        lock_nxt = ARB_LOCKED;
        lsrc_nxt = winner;
      end
    end
  end

  // Lock / pointer state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment only, so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      lock <= ARB_IDLE;
      ptr  <= '0;
      lsrc <= '0;
    end else begin
      lock <= lock_nxt;
      ptr  <= ptr_nxt;
      lsrc <= lsrc_nxt;
    end
  end

  // Output register: loads on transfer, empties when en finds no winner.
  always_ff @(posedge clk) begin
    // NOTE: the data path is reset too, so the output is deterministic after
    // reset rather than relying on i_0_valid to mask stale contents.
    if (!reset_n) begin
      i_0_valid <= 1'b0;
      i_0_data  <= '0;
      i_0_sel   <= '0;
      i_0_last  <= 1'b0;
    end else if (en) begin
      if (has_winner) begin
        i_0_valid <= 1'b1;
        i_0_data  <= win_data;
        i_0_sel   <= winner;
        i_0_last  <= win_last;
      end else begin
        i_0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eb_rr_arb.sv
// Self-checking bench for eb_rr_arb (N=4, T_WIDTH=8) with a behavioural model.
module tb_eb_rr_arb;

  localparam int N       = 4;
  localparam int T_WIDTH = 8;
  localparam int SEL_W   = 2;
  localparam int OBS_W   = N + 1 + T_WIDTH + SEL_W + 1;

  logic                 clk;
  logic                 reset_n;
  logic [N*T_WIDTH-1:0] t_data;
  logic [N-1:0]         t_last;
  logic [N-1:0]         t_valid;
  logic [N-1:0]         t_ready;
  logic [T_WIDTH-1:0]   i_0_data;
  logic [SEL_W-1:0]     i_0_sel;
  logic                 i_0_last;
  logic                 i_0_valid;
  logic                 i_0_ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int                 m_ptr;
  bit                 m_lock;
  int                 m_lsrc;
  bit                 m_valid;
  logic [T_WIDTH-1:0] m_data;
  logic [SEL_W-1:0]   m_sel;
  bit                 m_last;

  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] exp_obs;
  assign obs = {t_ready, i_0_valid, i_0_data, i_0_sel, i_0_last};

  eb_rr_arb #(.N(N), .T_WIDTH(T_WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .t_data    (t_data),
    .t_last    (t_last),
    .t_valid   (t_valid),
    .t_ready   (t_ready),
    .i_0_data  (i_0_data),
    .i_0_sel   (i_0_sel),
    .i_0_last  (i_0_last),
    .i_0_valid (i_0_valid),
    .i_0_ready (i_0_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner by the arbitration rules, or -1 when nobody may transfer.
  function automatic int model_winner();
    if (m_lock) return t_valid[m_lsrc] ? m_lsrc : -1;
    for (int off = 0; off < N; off++)
      if (t_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int w = model_winner();
    logic [N-1:0] r = '0;
    if (reset_n && (!m_valid || i_0_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [OBS_W-1:0] model_obs();
    return {model_ready(), m_valid, m_data, m_sel, m_last};
  endfunction

  // Advance model and DUT by one clock; returns at the following falling edge.
  task automatic tick();
    int w;
    bit can_load;
    w        = model_winner();
    can_load = !m_valid || i_0_ready;
    @(posedge clk);
    if (!reset_n) begin
      m_ptr = 0; m_lock = 0; m_lsrc = 0;
      m_valid = 0; m_data = '0; m_sel = '0; m_last = 0;
    end else if (can_load) begin
      if (w >= 0) begin
        m_valid = 1;
        m_data  = t_data[w*T_WIDTH +: T_WIDTH];
        m_sel   = SEL_W'(w);
        m_last  = t_last[w];
        if (t_last[w]) begin
          m_lock = 0;
          m_ptr  = (w + 1) % N;
        end else begin
          m_lock = 1;
          m_lsrc = w;
        end
      end else begin
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_tags();
    for (int k = 0; k < N; k++) t_data[k*T_WIDTH +: T_WIDTH] = 8'(8'hA0 + k);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    t_valid   = '1;
    t_last    = '1;
    i_0_ready = 1'b1;
    set_tags();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (t_ready !== 4'b0000 || i_0_valid !== 1'b0 || i_0_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: t_ready=%b valid=%b sel=%0d, want 0000/0/0", t_ready, i_0_valid, i_0_sel);
      end
      tick();
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (t_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: t_ready=%b want 0001", t_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    t_valid   = '1;
    t_last    = '1;
    i_0_ready = 1'b1;
    set_tags();
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_obs = model_obs();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL round_robin c%0d: got %h want %h", c, obs, exp_obs);
      end
      tick();
    end
  endtask

  task automatic test_packet_lock();
    int  b = 0;
    bit  gap_done = 0;
    bit  gap_now;
    int  budget;
    logic [N-1:0] er;
    i_0_ready = 1'b1;
    t_last    = 4'b0011;
    set_tags();
    for (budget = 0; budget < 20 && b < 3; budget++) begin
      gap_now    = (b == 1) && !gap_done;
      if (gap_now) gap_done = 1;
      t_valid    = {1'b0, !gap_now, 2'b11};
      t_last[2]  = (b == 2);
      t_data[2*T_WIDTH +: T_WIDTH] = 8'(8'hC0 + b);
      #1;
      exp_obs = model_obs();
      er      = model_ready();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL packet_lock b%0d: got %h want %h", b, obs, exp_obs);
      end
      if (er[2]) b++;
      tick();
    end
    checks++;
    if (b < 3) begin
      errors++;
      $display("FAIL packet_lock_timeout: beats=%0d want 3", b);
    end
    t_valid = 4'b0011;
    #1;
    checks++;
    if (i_0_sel !== 2'd2 || i_0_last !== 1'b1 || i_0_data !== 8'hC2 || t_ready !== 4'b0001) begin
      errors++;
      $display("FAIL packet_after: sel=%0d last=%b data=%h t_ready=%b, want 2/1/c2/0001",
               i_0_sel, i_0_last, i_0_data, t_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    set_tags();
    t_last    = '1;
    i_0_ready = 1'b1;
    t_valid   = '0;
    tick();
    i_0_ready = 1'b0;
    t_valid   = 4'b0001;
    t_data[0 +: T_WIDTH] = 8'h5C;
    tick();
    t_data[0 +: T_WIDTH] = 8'h5D;
    t_valid = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_obs = model_obs();
      checks++;
      if (i_0_data !== 8'h5C || t_ready !== 4'b0000 || i_0_valid !== 1'b1 || obs !== exp_obs) begin
        errors++;
        $display("FAIL backpressure_hold c%0d: data=%h t_ready=%b valid=%b, want 5c/0000/1",
                 c, i_0_data, t_ready, i_0_valid);
      end
      tick();
    end
    i_0_ready = 1'b1;
    #1;
    checks++;
    if (t_ready !== 4'b0010) begin
      errors++;
      $display("FAIL backpressure_release: t_ready=%b want 0010", t_ready);
    end
    tick();
    checks++;
    if (i_0_valid !== 1'b1 || i_0_sel !== 2'd1 || i_0_data !== 8'hA1) begin
      errors++;
      $display("FAIL backpressure_reload: valid=%b sel=%0d data=%h, want 1/1/a1", i_0_valid, i_0_sel, i_0_data);
    end
  endtask

  task automatic test_wrap_sparse();
    set_tags();
    t_last    = '1;
    i_0_ready = 1'b1;
    t_valid   = '0;
    tick();
    t_valid = 4'b0100;
    tick();
    t_valid = 4'b0010;
    #1;
    checks++;
    if (t_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_grant: t_ready=%b want 0010", t_ready);
    end
    tick();
    checks++;
    if (dut.ptr !== 2'd2) begin
      errors++;
      $display("FAIL wrap_ptr: ptr=%0d want 2", dut.ptr);
    end
    t_valid = '1;
    #1;
    checks++;
    if (t_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_next: t_ready=%b want 0100", t_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    set_tags();
    i_0_ready = 1'b1;
    t_last    = '0;
    t_valid   = 4'b0010;
    tick();
    checks++;
    if (dut.lock !== 1'b1 || i_0_valid !== 1'b1 || i_0_sel !== 2'd1) begin
      errors++;
      $display("FAIL midpkt_locked: lock=%b valid=%b sel=%0d, want 1/1/1", dut.lock, i_0_valid, i_0_sel);
    end
    reset_n = 1'b0;
    t_valid = '1;
    #1;
    checks++;
    if (t_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midpkt_reset_ready: t_ready=%b want 0000", t_ready);
    end
    tick();
    checks++;
    if (dut.lock !== 1'b0 || i_0_valid !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_cleared: lock=%b valid=%b, want 0/0", dut.lock, i_0_valid);
    end
    reset_n = 1'b1;
    t_last  = '1;
    #1;
    checks++;
    if (t_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midpkt_restart: t_ready=%b want 0001", t_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      reset_n   = ($urandom_range(0, 63) != 0);
      t_valid   = N'($urandom);
      t_last    = N'($urandom) | N'($urandom);
      t_data    = ($urandom);
      i_0_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_obs = model_obs();
      checks++;
      if (obs !== exp_obs) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", c, obs, exp_obs);
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    t_data    = '0;
    t_last    = '0;
    t_valid   = '0;
    i_0_ready = 1'b0;
    m_ptr = 0; m_lock = 0; m_lsrc = 0;
    m_valid = 0; m_data = '0; m_sel = '0; m_last = 0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_wrap_sparse();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eb_rr_arb.md
# eb_rr_arb

Round-robin arbiter that shares one elastic-buffer output stage between N valid/ready requesters. It selects one requester per cycle, registers the winning word plus its source index into a single full-throughput output register, and holds the grant across multi-beat packets marked by `last`. It sits in front of a shared downstream consumer wherever several pipelines converge.

## Interface
Parameters:
- `N`, 4, number of requesters, legal range 2..16.
- `T_WIDTH`, 8, data width of each requester and of the output.
- `SEL_W`, `$clog2(N)`, width of the source index (derived; never overridden).

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `t_data`  in  N*T_WIDTH  requester data; requester k owns bits [k*T_WIDTH +: T_WIDTH].
- `t_last`  in  N  end-of-packet flag for each requester; a single-beat packet has `last`=1.
- `t_valid`  in  N  requester valid.
- `t_ready`  out  N  requester ready; at most one bit is high in any cycle.
- `i_0_data`  out  T_WIDTH  registered output data.
- `i_0_sel`  out  SEL_W  index of the requester that supplied `i_0_data`.
- `i_0_last`  out  1  registered copy of the winner's `last`.
- `i_0_valid`  out  1  output valid.
- `i_0_ready`  in  1  downstream ready.

## Operation
- Define `en = ~i_0_valid | i_0_ready`. The output register can load whenever `en` is high.
- State is held in the following registers:
  - `ptr` (SEL_W): round-robin start index.
  - `lock` (1).
  - `lsrc` (SEL_W): the locked source.
  - The output register: `i_0_data`, `i_0_sel`, `i_0_last`, `i_0_valid`.
- Pick rule when `lock`=0: the winner is the first k with `t_valid[k]`=1, scanning `ptr`, `ptr+1`, … modulo N.
- Pick rule when `lock`=1: the winner is `lsrc` only, and only if `t_valid[lsrc]`=1. Otherwise there is no winner. Other requesters stall even while the locked source is idle.
- `t_ready[k] = en & (winner == k)`. The combinational path from `t_valid` to `t_ready` is allowed. `t_ready` never depends on `i_0_valid` other than through `en`.
- Transfer (`en` and a winner exists) causes the following updates:
  - The output register loads the winner's data, index and `last`, and `i_0_valid` is set to 1.
  - If `last`=0: `lock` is set to 1 and `lsrc` is set to the winner.
  - If `last`=1: `lock` is cleared and `ptr` is set to (winner+1) mod N.
- `en` with no winner: `i_0_valid` is set to 0. Data, sel and last hold their values.
- `en`=0: nothing changes.
- `ptr` advances only on packet completion, never on mid-packet beats.
- Lock and pointer state machine:
  - States are IDLE (`lock`=0) and LOCKED (`lock`=1).
  - IDLE→LOCKED on a transfer with `last`=0.
  - LOCKED→IDLE on a transfer with `last`=1.
  - All other cases hold the current state.

## Timing
- The following registers reset to zero when `reset_n`=0 at a clock edge: `i_0_valid`, `i_0_data`, `i_0_sel`, `i_0_last`, `ptr`, `lock`, `lsrc`.
- While `reset_n`=0, `t_ready` is 0.
- Reset mid-packet drops the lock and any word held in the output register.
- Latency: one cycle from transfer to `i_0_valid`.
- Throughput: one beat per cycle while `i_0_ready`=1, with no bubble on source switch.
- Once `i_0_valid`=1, it and the output data stay stable until `i_0_valid & i_0_ready`.
- Simultaneous output accept and new transfer in one cycle: the register reloads with no bubble.
- Wrap-around: with `ptr`=N-1, the scan order is N-1, 0, 1, …
- Fairness: a continuously valid requester is granted within N packet completions.

## Structure
- Package `eb_arb_pkg`:
  - Lock-state encoding constants `ARB_IDLE`/`ARB_LOCKED`.
  - A function returning the SEL_W for a given N.
- Sub-module `rr_pick`: purely combinational rotate-and-priority-encode.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `gnt_idx`, `gnt_any`.
  - Reused by other arbiters.
- Top level holds `en`, lock/ptr registers and the output register. Target size is 150–250 lines.

## Test plan
- Reset, N=4: hold `reset_n`=0 for 3 cycles with all `t_valid`=1.
  - Required: `t_ready`=0000, `i_0_valid`=0, `i_0_sel`=0.
  - After release, the first grant is k=0.
- Round robin: all four requesters send single-beat packets continuously with `i_0_ready`=1.
  - Required: `i_0_sel` sequence 0,1,2,3,0,1…, one beat per cycle.
  - Data equals the per-requester tag (e.g. 8'hA0+k).
- Packet lock: requester 2 sends 3 beats (`last`=0,0,1) while 0 and 1 are also valid.
  - Required: three consecutive outputs have `i_0_sel`=2, even with a one-cycle `t_valid[2]`=0 gap.
  - Next grant after the packet is 3 if valid, else 0.
- Backpressure: hold `i_0_ready`=0 for 5 cycles with output full at 8'h5C.
  - Required: `i_0_data` stable at 8'h5C, `t_ready`=0000.
  - On release, the next word loads in the same cycle as the accept.
- Wrap and sparse: `ptr`=3 with only `t_valid[1]`=1.
  - Required: grant 1, then `ptr`=2.
- Reset mid-packet: assert `reset_n`=0 during a locked packet from requester 1.
  - Required: `lock`=0 and `i_0_valid`=0 next cycle; afterwards requester 0 wins.
